buttons_pio_irq: RTL

- Parametrised Avalon-MM input PIO for push-buttons and switches; successor to the fixed 2-bit, read-only button port.
- Per channel: input synchroniser, optional debounce filter, edge capture.
- Maskable level interrupt to the Nios II processor.
- Sits on the system interconnect as an s1 slave; readdata is registered with 1-cycle read latency.

---
 rtl/buttons_pio_irq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/buttons_pio_irq.sv
// Avalon-MM input PIO for buttons/switches: per-channel synchroniser, debounce, edge capture, maskable irq.
// Define BUTTONS_DEBOUNCE_EN to enable the debounce filter; otherwise stable levels follow the synchroniser.

module buttons_pio_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic clr,
    output logic stable,
    output logic cap
);
    localparam logic IDLE = IDLE_LEVEL[0];

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   prev;
    logic                   edge_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {SYNC_STAGES{IDLE}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef BUTTONS_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          stable_q;

    // A new level is accepted only after it has persisted DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            stable_q <= IDLE;
        end else if (sync == stable_q) begin
            cnt <= '0;
        end else if (cnt == CMAX) begin
            stable_q <= sync;
            cnt      <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync;
`endif

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit = stable & ~prev;
            1:       edge_hit = ~stable & prev;
            default: edge_hit = stable ^ prev;
        endcase
    end

    // A detected edge takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= IDLE;
            cap  <= 1'b0;
        end else begin
            prev <= stable;
            if (edge_hit)  cap <= 1'b1;
            else if (clr)  cap <= 1'b0;
        end
    end
endmodule

module buttons_pio_irq #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_bits;

    assign wr          = chipselect && write;
    assign clr         = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign unused_bits = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        buttons_pio_lane #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_TYPE      (EDGE_TYPE),
            .IDLE_LEVEL     (IDLE_LEVEL)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .raw   (in_port[i]),
            .clr   (clr[i]),
            .stable(stable[i]),
            .cap   (edgecap[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       irqmask <= '0;
        else if (wr && address == 2'd2)  irqmask <= writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = stable;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecap;
            default: rd_mux = '0;
        endcase
    end

    // Read mux is registered every cycle regardless of chipselect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end

    assign irq = |(edgecap & irqmask);
endmodule
